// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter driving a 3-8 decoder select with a registered index and one-hot grant.
// Optional hold timeout under contention: define RR_ARBITER8_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] req,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       gnt_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [7:0]  req_rot;
  logic [2:0]  pick_off;
  logic [2:0]  pick_idx;
  logic        owner_req;
  logic        others_req;
  logic        timeout;

  // Rotate so that bit 0 is the pointer position; the lowest set bit is the winner.
  always_comb begin
    req_rot  = 8'({req, req} >> ptr_q);
    pick_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 3'(i);
    end
    pick_idx = ptr_q + pick_off;
  end

  assign owner_req  = req[gnt_idx];
  assign others_req = |(req & ~gnt);

`ifdef RR_ARBITER8_TIMEOUT_EN
  assign timeout = (hold_cnt_q == MaxHold) && owner_req && others_req;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      ptr_q      <= 3'd0;
      hold_cnt_q <= '0;
      gnt_idx    <= 3'd0;
      gnt        <= 8'h00;
      gnt_valid  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q    <= StGrant;
            gnt_idx    <= pick_idx;
            gnt        <= 8'b1 << pick_idx;
            gnt_valid  <= 1'b1;
            hold_cnt_q <= CNT_W'(1);
          end else begin
            gnt        <= 8'h00;
            gnt_valid  <= 1'b0;
          end
        end
        StGrant: begin
          if (!owner_req || timeout) begin
            // gnt_idx is kept so the decoder select stays stable while idle.
            state_q    <= StIdle;
            ptr_q      <= gnt_idx + 3'd1;
            hold_cnt_q <= '0;
            gnt        <= 8'h00;
            gnt_valid  <= 1'b0;
          end else if (hold_cnt_q != MaxHold) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= StIdle;
          gnt       <= 8'h00;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a behavioural model predicts each cycle's outputs,
// directed sections check the listed scenarios against fixed values.
module tb_rr_arbiter8;

  localparam int unsigned MaxHold = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] req     = 8'h00;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  // model state
  logic       m_valid;
  logic [2:0] m_idx;
  logic [2:0] m_ptr;
  int         m_hold;

  rr_arbiter8 #(
    .MAX_HOLD(MaxHold),
    .CNT_W   (5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .gnt_idx  (gnt_idx),
    .gnt      (gnt),
    .gnt_valid(gnt_valid)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 3'd0;
    m_ptr   = 3'd0;
    m_hold  = 0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    bit rel;
    int c;
    if (!m_valid) begin
      for (int i = 0; i < 8; i++) begin
        c = (int'(m_ptr) + i) % 8;
        if (r[c]) begin
          m_idx   = 3'(c);
          m_valid = 1'b1;
          m_hold  = 1;
          break;
        end
      end
    end else begin
      rel = !r[m_idx];
`ifdef RR_ARBITER8_TIMEOUT_EN
      if (m_hold == MaxHold && r[m_idx] && ((r & ~(8'h01 << m_idx)) != 8'h00)) rel = 1'b1;
`endif
      if (rel) begin
        m_valid = 1'b0;
        m_ptr   = 3'((int'(m_idx) + 1) % 8);
        m_hold  = 0;
      end else if (m_hold < MaxHold) begin
        m_hold++;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic [7:0] r);
    logic [11:0] want;
    @(negedge sys_clk);
    req = r;
    model_edge(r);
    exp_q.push_back({m_valid, m_idx, m_valid ? (8'h01 << m_idx) : 8'h00});
    @(posedge sys_clk);
    #1;
    want = exp_q.pop_front();
    chk("scoreboard", {20'h0, gnt_valid, gnt_idx, gnt}, {20'h0, want});
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    req     = 8'hFF;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk);
      #1;
      chk("rst_gnt", {24'h0, gnt}, 32'h0);
      chk("rst_valid", {31'h0, gnt_valid}, 32'h0);
      chk("rst_idx", {29'h0, gnt_idx}, 32'h0);
    end
    @(negedge sys_clk);
    req     = 8'h00;
    sys_rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // single request, then release and pointer-based pick
    step(8'h08);
    chk("single_idx", {29'h0, gnt_idx}, 32'd3);
    chk("single_gnt", {24'h0, gnt}, 32'h08);
    step(8'h00);
    chk("single_rel", {31'h0, gnt_valid}, 32'd0);
    chk("single_idx_hold", {29'h0, gnt_idx}, 32'd3);
    step(8'h09);
    chk("ptr4_idx", {29'h0, gnt_idx}, 32'd0);
    chk("ptr4_gnt", {24'h0, gnt}, 32'h01);
    step(8'h00);

    // rotation with one idle cycle between grants
    do_reset();
    for (int n = 0; n < 9; n++) begin
      step(8'hFF);
      chk("rot_idx", {29'h0, gnt_idx}, 32'(n % 8));
      chk("rot_valid", {31'h0, gnt_valid}, 32'd1);
      step(8'hFF);
      step(8'hFF & ~(8'h01 << (n % 8)));
      chk("rot_idle", {31'h0, gnt_valid}, 32'd0);
    end

    // wrap: serve 6 so the pointer sits at 7
    step(8'h40);
    step(8'h00);
    step(8'h41);
    chk("wrap_idx", {29'h0, gnt_idx}, 32'd0);
    chk("wrap_gnt", {24'h0, gnt}, 32'h01);
    step(8'h00);
    step(8'h40);
    chk("wrap_idx6", {29'h0, gnt_idx}, 32'd6);
    step(8'h00);

    // asynchronous reset between edges while a grant is active
    step(8'h04);
    chk("pre_rst_valid", {31'h0, gnt_valid}, 32'd1);
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_gnt", {24'h0, gnt}, 32'h0);
    chk("async_valid", {31'h0, gnt_valid}, 32'h0);
    chk("async_idx", {29'h0, gnt_idx}, 32'h0);
    do_reset();

`ifdef RR_ARBITER8_TIMEOUT_EN
    // contention: 4 cycles owner 0, idle, 4 cycles owner 1, idle, ...
    for (int c = 1; c <= 20; c++) begin
      step(8'h03);
      if (c % 5 == 0) chk("to_idle", {24'h0, gnt}, 32'h0);
      else chk("to_gnt", {24'h0, gnt}, ((c - 1) / 5) % 2 == 0 ? 32'h01 : 32'h02);
    end
    step(8'h00);
    step(8'h00);
    for (int c = 0; c < 55; c++) begin
      step(8'h01);
      chk("to_alone", {24'h0, gnt}, 32'h01);
    end
`else
    // no timeout: owner 0 keeps the grant regardless of other requesters
    for (int c = 0; c < 30; c++) begin
      step(8'h03 | (8'($urandom) & 8'hFC));
      chk("hold_gnt", {24'h0, gnt}, 32'h01);
    end
    step(8'h02);
    chk("hold_rel", {31'h0, gnt_valid}, 32'd0);
    step(8'h02);
    chk("hold_next", {24'h0, gnt}, 32'h02);
`endif
    step(8'h00);

    // random traffic, scoreboard only
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(3) == 0) step(8'h00);
      else step(8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
